// File: rtl/alu_pkg.sv
// Shared decode constants and the issue-stage record for the RV32I ALU issue/writeback stage.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;

  typedef enum logic [2:0] {
    ADD_SUB = 3'd0,
    SLL     = 3'd1,
    SLT     = 3'd2,
    SLTU    = 3'd3,
    XOR     = 3'd4,
    SRL_SRA = 3'd5,
    OR      = 3'd6,
    AND     = 3'd7
  } funct3_e;

  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;
  localparam logic [6:0] F7_INVALID = 7'h7F;

  // Operands and control held in the ISSUE register and presented to the ALU.
  typedef struct packed {
    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    funct3_e         op;
    logic [6:0]      meta;
    logic [4:0]      rd;
  } issue_t;

  // Shift encodings take a 5-bit shamt instead of a full operand.
  function automatic logic is_shift(input funct3_e f);
    return (f == SLL) || (f == SRL_SRA);
  endfunction

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational decode of an RV32I OP / OP-IMM word plus register data into ALU operands.
module rv_alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_t          dec,
  output logic            uses_rs2
);

  logic [6:0] opcode;
  funct3_e    f3;

  assign opcode = instr[6:0];
  assign f3     = funct3_e'(instr[14:12]);

  // Select operands per opcode; unknown opcodes get a funct7 no ALU accepts so they retire as illegal.
  always_comb begin
    dec.lhs  = rs1_data;
    dec.rhs  = rs2_data;
    dec.op   = f3;
    dec.meta = instr[31:25];
    dec.rd   = instr[11:7];
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        uses_rs2 = 1'b1;
        if (is_shift(f3)) begin
          dec.rhs = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
        end
      end
      OPC_OP_IMM: begin
        if (is_shift(f3)) begin
          dec.rhs  = {{(XLEN-5){1'b0}}, instr[24:20]};
          dec.meta = instr[31:25];
        end else begin
          // Immediate bits share the funct7 field; keep them out of the ALU's funct7.
          dec.rhs  = {{(XLEN-12){instr[31]}}, instr[31:20]};
          dec.meta = F7_BASE;
        end
      end
      default: begin
        dec.op   = ADD_SUB;
        dec.meta = F7_INVALID;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage ALU issue/writeback with a RAW scoreboard (regfile has no bypass path).
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] alu_lhs,
  output logic [DATA_WIDTH-1:0] alu_rhs,
  output logic [2:0]            alu_operation,
  output logic [6:0]            alu_metadata,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_valid,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_illegal
);

  issue_t                dec_next;
  logic                  uses_rs2;
  issue_t                issue_reg;
  logic                  issue_v_reg;
  logic                  wb_v_reg;
  logic [4:0]            wb_rd_reg;
  logic [DATA_WIDTH-1:0] wb_data_reg;
  logic                  wb_illegal_reg;
  logic                  wb_adv;
  logic                  hazard;
  logic                  accept;
  logic [1:0][4:0]       src_addr;
  logic [1:0]            src_used;
  logic [1:0]            src_hit;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  rv_alu_decode u_decode (
    .instr    (in_instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec_next),
    .uses_rs2 (uses_rs2)
  );

  // rs1 is always read; rs2 only matters for register-register ops.
  assign src_addr[0] = rs1_addr;
  assign src_addr[1] = rs2_addr;
  assign src_used    = {uses_rs2, 1'b1};

  // A source conflicts with any pending producer; illegal WB entries never write, so they don't block.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src_addr[gi] != 5'd0) &&
                           ((issue_v_reg && (issue_reg.rd == src_addr[gi])) ||
                            (wb_v_reg && !wb_illegal_reg && (wb_rd_reg == src_addr[gi])));
    end
  endgenerate

  assign hazard   = |src_hit;
  assign wb_adv   = issue_v_reg && (!wb_v_reg || wb_ready);
  assign in_ready = !flush && !hazard && (!issue_v_reg || wb_adv);
  assign accept   = in_valid && in_ready;

  // Stage occupancy: flush empties both stages, otherwise entries move forward in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_v_reg <= 1'b0;
      wb_v_reg    <= 1'b0;
    end else if (flush) begin
      issue_v_reg <= 1'b0;
      wb_v_reg    <= 1'b0;
    end else begin
      if (accept) begin
        issue_v_reg <= 1'b1;
      end else if (wb_adv) begin
        issue_v_reg <= 1'b0;
      end
      if (wb_adv) begin
        wb_v_reg <= 1'b1;
      end else if (wb_ready) begin
        wb_v_reg <= 1'b0;
      end
    end
  end

  // Stage payloads; an unrecognised ALU op is captured as an illegal entry with zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_reg      <= '0;
      wb_rd_reg      <= 5'd0;
      wb_data_reg    <= '0;
      wb_illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        issue_reg <= dec_next;
      end
      if (wb_adv) begin
        wb_rd_reg      <= issue_reg.rd;
        wb_data_reg    <= alu_valid ? alu_result : '0;
        wb_illegal_reg <= !alu_valid;
      end
    end
  end

  assign alu_lhs       = issue_reg.lhs;
  assign alu_rhs       = issue_reg.rhs;
  assign alu_operation = issue_reg.op;
  assign alu_metadata  = issue_reg.meta;

  assign wb_valid   = wb_v_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_data    = wb_data_reg;
  assign wb_illegal = wb_illegal_reg;

endmodule
